// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: turns the microcode mcontrol field into one read
// or one write on a synchronous single-port RAM with a configurable read latency.
module data_mem_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        mcontrol,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wr_done,
    output logic              busy,
    output logic              req_drop
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT);

    localparam logic [1:0] MC_IDLE  = 2'b00;
    localparam logic [1:0] MC_READ  = 2'b01;
    localparam logic [1:0] MC_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_WR      = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mc_prev_q, mc_prev_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              wr_done_q, wr_done_d;
    logic              busy_q, busy_d;
    logic              req_drop_q, req_drop_d;
    logic              new_req_s;

    // A held mcontrol level is a single request; only a change to a nonzero code starts one.
    assign new_req_s = (mcontrol != MC_IDLE) && (mcontrol != mc_prev_q);

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mc_prev_d     = mcontrol;
        ram_en_d      = ram_en_q;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        wr_done_d     = 1'b0;
        busy_d        = busy_q;
        req_drop_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (new_req_s) begin
                    case (mcontrol)
                        MC_READ: begin
                            ram_addr_d = addr_in;
                            ram_en_d   = 1'b1;
                            busy_d     = 1'b1;
                            cnt_d      = CNT_LOAD;
                            state_d    = ST_RD_WAIT;
                        end
                        MC_WRITE: begin
                            ram_addr_d  = addr_in;
                            ram_wdata_d = wdata_in;
                            ram_en_d    = 1'b1;
                            ram_we_d    = 1'b1;
                            busy_d      = 1'b1;
                            state_d     = ST_WR;
                        end
                        default: begin
                            req_drop_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                req_drop_d = new_req_s;
                // The extra count step leaves one clock for the RAM output to settle before capture.
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    rdata_d       = ram_rdata;
                    rdata_valid_d = 1'b1;
                    ram_en_d      = 1'b0;
                    busy_d        = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            ST_WR: begin
                req_drop_d = new_req_s;
                ram_en_d   = 1'b0;
                wr_done_d  = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                ram_en_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            mc_prev_q     <= 2'b00;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= {ADDR_W{1'b0}};
            ram_wdata_q   <= {DATA_W{1'b0}};
            rdata_q       <= {DATA_W{1'b0}};
            rdata_valid_q <= 1'b0;
            wr_done_q     <= 1'b0;
            busy_q        <= 1'b0;
            req_drop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mc_prev_q     <= mc_prev_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            wr_done_q     <= wr_done_d;
            busy_q        <= busy_d;
            req_drop_q    <= req_drop_d;
        end
    end

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign wr_done     = wr_done_q;
    assign busy        = busy_q;
    assign req_drop    = req_drop_q;

endmodule
